iq_demod: RTL
=============

Name: iq_demod

Overview:
- Quadrature correlating demodulator (lock-in style) for I/Q sample streams in the same offset-binary format the modulator chain produces.
- Removes the per-channel zero level and multiplies each channel by a local sine reference. The reference comes from a phase accumulator and the codebase sin_lut.
- Integrates the products over frames of 2^ACC_LOG2 accepted samples and emits one signed correlation pair per frame.
- Used for loopback calibration and amplitude/phase measurement of the modulator output.

Parameters:
- BIT_WIDTH, 10: sample, zero-level and sin_lut output width.
- ADDR_MAX, 1024: sine table depth, power of two; AW = clog2(ADDR_MAX).
- ACC_LOG2, 8: log2 of samples per frame.

Ports:
- clk_in  in  1  clock; all logic on the rising edge.
- rst_in  in  1  asynchronous reset, active low.
- en_in  in  1  run enable; low = idle, reload phase, discard any partial frame.
- in_valid  in  1  I_in/Q_in hold a sample this cycle.
- I_in  in  BIT_WIDTH  unsigned offset-binary I sample.
- Q_in  in  BIT_WIDTH  unsigned offset-binary Q sample.
- zero_lvl_I  in  BIT_WIDTH  I zero level, subtracted from I_in.
- zero_lvl_Q  in  BIT_WIDTH  Q zero level, subtracted from Q_in.
- step  in  AW  phase increment per accepted sample.
- phase_zero_I  in  AW  I accumulator start phase.
- phase_zero_Q  in  AW  Q accumulator start phase.
- phase_I  in  AW  I lookup offset.
- phase_Q  in  AW  Q lookup offset.
- corr_I  out  CW = 2*BIT_WIDTH+2+ACC_LOG2  signed I frame correlation.
- corr_Q  out  CW  signed Q frame correlation.
- out_valid  out  1  one-cycle pulse when corr_I/corr_Q update.
- busy  out  1  high while a frame is partially accumulated or still in the pipeline.

Behaviour:
- Reset (rst_in low, asynchronous):
  - addr_I <= phase_zero_I, addr_Q <= phase_zero_Q.
  - Accumulators, sample counter, pipeline valids, corr_I, corr_Q, out_valid and busy all 0.
  - FSM enters IDLE.
- FSM IDLE:
  - Entered whenever en_in = 0; stays while en_in = 0. No samples accepted.
  - addr reloads from phase_zero_* every cycle.
  - Accumulators, counter and pipeline valids cleared; corr_* hold their last values.
  - Moves to RUN on the first edge with en_in = 1.
- FSM RUN:
  - A sample is accepted at an edge where en_in = 1 and in_valid = 1. There is no back-pressure.
  - On each accept, addr_I/addr_Q += step, wrapping modulo ADDR_MAX.
  - Cycles with in_valid = 0 hold phase, counter and accumulators.
- Stage 1 (registered at the accepting edge):
  - dI = I_in - zero_lvl_I, computed as BIT_WIDTH+1 signed.
  - rI = sin_lut(addr_I + phase_I, mod ADDR_MAX) - 2^(BIT_WIDTH-1), BIT_WIDTH+1 signed.
  - Q channel identical using the Q inputs and addr_Q.
- Stage 2 (next edge): pI = dI*rI and pQ = dQ*rQ, each 2*BIT_WIDTH+2 signed.
- Stage 3 (next edge):
  - acc += p. The counter increments per stage-2 valid.
  - On the 2^ACC_LOG2-th product: corr <= acc + p, acc <= 0, counter <= 0, out_valid = 1 for one cycle.
- Latency: corr_* and out_valid update at the second edge after the edge accepting the frame's last sample.
- Back-to-back frames need no gap; the first product of the next frame starts the fresh accumulation in the same cycle as the dump.
- Widths: CW cannot overflow; no saturation is required.
- busy = (RUN and (counter != 0 or any pipeline valid)).
- en_in falling mid-frame:
  - Partial frame and in-flight pipeline data are discarded; no out_valid is generated.
  - Phase reloads; the next RUN starts a full new frame.
- step = 0: phase is constant (DC reference).
- Sample at the address wrap: lookup uses the wrapped address; no glitch.

Test Plan:
- Reset hold with random inputs -> corr_I = corr_Q = 0, out_valid = 0, busy = 0; after release with en_in = 0, addr equals phase_zero_*.
- ACC_LOG2 = 4, I_in = Q_in = zero_lvl = 512, step = 37, 16 valids -> one out_valid, corr_I = corr_Q = 0.
- ACC_LOG2 = 4, step = 0, phase_zero_I = 256, phase_I = 0, sin_lut(256) = 1023, I_in = 612, zero_lvl_I = 512, 16 valids -> corr_I = 16*100*511 = 817600, out_valid 2 edges after the last accept.
- ACC_LOG2 = 4, 48 consecutive valids -> exactly 3 out_valid pulses 16 cycles apart, each frame matching the reference model; busy stays 1 throughout.
- ACC_LOG2 = 4, in_valid alternating 1/0 for 32 cycles -> phase advances only on valids; one pulse after 16 accepts; corr matches a gap-free model.
- en_in dropped after 10 samples, then 16 more -> no pulse for the partial frame; the next pulse equals the model from phase_zero_*.

Source files
------------

// File: rtl/iq_demod.sv
// Quadrature correlating demodulator: removes the zero level from each I/Q sample, multiplies
// it by a sine reference and integrates the products over frames of 2^ACC_LOG2 accepted samples.
module iq_demod #(
    parameter int BIT_WIDTH = 10,
    parameter int ADDR_MAX  = 1024,
    parameter int ACC_LOG2  = 8,
    localparam int AW = $clog2(ADDR_MAX),
    localparam int CW = 2*BIT_WIDTH+2+ACC_LOG2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 en_in,
    input  logic                 in_valid,
    input  logic [BIT_WIDTH-1:0] I_in,
    input  logic [BIT_WIDTH-1:0] Q_in,
    input  logic [BIT_WIDTH-1:0] zero_lvl_I,
    input  logic [BIT_WIDTH-1:0] zero_lvl_Q,
    input  logic [AW-1:0]        step,
    input  logic [AW-1:0]        phase_zero_I,
    input  logic [AW-1:0]        phase_zero_Q,
    input  logic [AW-1:0]        phase_I,
    input  logic [AW-1:0]        phase_Q,
    output logic [CW-1:0]        corr_I,
    output logic [CW-1:0]        corr_Q,
    output logic                 out_valid,
    output logic                 busy
);
    localparam int DW   = BIT_WIDTH + 1;
    localparam int PW   = 2*BIT_WIDTH + 2;
    localparam int QTR  = ADDR_MAX / 4;
    localparam int HALF = 2**(BIT_WIDTH-1);
    localparam int AMP  = HALF - 1;
    localparam longint PI_Q30 = 64'sd3373259426;

    typedef enum logic {IDLE, RUN} state_t;

    // Table entry: HALF + round(AMP*sin(2*pi*a/ADDR_MAX)), evaluated in Q30 by quarter-wave Taylor series.
    function automatic int sine_val(input int a);
        longint x, term, sum, mag;
        int q, r, rr;
        q  = a / QTR;
        r  = a % QTR;
        rr = (q == 1 || q == 3) ? QTR - r : r;
        x  = (longint'(rr) * longint'(2) * PI_Q30) / longint'(ADDR_MAX);
        term = x;
        sum  = x;
        for (int k = 1; k <= 7; k++) begin
            term = (((term * x) >>> 30) * x) >>> 30;
            term = -term / longint'((2*k) * (2*k+1));
            sum  = sum + term;
        end
        mag = (longint'(AMP) * sum + (longint'(1) <<< 29)) >>> 30;
        return (q >= 2) ? HALF - int'(mag) : HALF + int'(mag);
    endfunction

    function automatic logic signed [DW-1:0] offset_sub(input logic [BIT_WIDTH-1:0] a,
                                                        input logic [BIT_WIDTH-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    function automatic logic signed [CW-1:0] sext(input logic signed [PW-1:0] p);
        return {{(CW-PW){p[PW-1]}}, p};
    endfunction

    logic [BIT_WIDTH-1:0] rom [ADDR_MAX];
    for (genvar g = 0; g < ADDR_MAX; g++) begin : g_rom
        localparam logic [BIT_WIDTH-1:0] V = BIT_WIDTH'(sine_val(g));
        assign rom[g] = V;
    end

    state_t               state;
    logic [AW-1:0]        addr_i, addr_q;
    logic [AW-1:0]        lut_addr_i, lut_addr_q;
    logic                 accept;
    logic                 vld_p1, vld_p2;
    logic signed [DW-1:0] d_i_p1, d_q_p1, r_i_p1, r_q_p1;
    logic signed [PW-1:0] p_i_p2, p_q_p2;
    logic signed [CW-1:0] acc_i, acc_q;
    logic [ACC_LOG2-1:0]  cnt;

    assign lut_addr_i = addr_i + phase_I;
    assign lut_addr_q = addr_q + phase_Q;
    assign accept     = (state == RUN) && en_in && in_valid;
    assign busy       = (state == RUN) && ((cnt != '0) || vld_p1 || vld_p2);

    always_ff @(posedge clk_in) begin
        // p1: zero-level removal and centred reference
        if (accept) begin
            d_i_p1 <= offset_sub(I_in, zero_lvl_I);
            d_q_p1 <= offset_sub(Q_in, zero_lvl_Q);
            r_i_p1 <= offset_sub(rom[lut_addr_i], BIT_WIDTH'(HALF));
            r_q_p1 <= offset_sub(rom[lut_addr_q], BIT_WIDTH'(HALF));
        end
        // p2: products
        if (vld_p1) begin
            p_i_p2 <= PW'(d_i_p1) * PW'(r_i_p1);
            p_q_p2 <= PW'(d_q_p1) * PW'(r_q_p1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            addr_i    <= phase_zero_I;
            addr_q    <= phase_zero_Q;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            acc_i     <= '0;
            acc_q     <= '0;
            cnt       <= '0;
            corr_I    <= '0;
            corr_Q    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (!en_in) begin
                state  <= IDLE;
                addr_i <= phase_zero_I;
                addr_q <= phase_zero_Q;
                vld_p1 <= 1'b0;
                vld_p2 <= 1'b0;
                acc_i  <= '0;
                acc_q  <= '0;
                cnt    <= '0;
            end else begin
                state <= RUN;
                if (accept) begin
                    addr_i <= addr_i + step;
                    addr_q <= addr_q + step;
                end
                vld_p1 <= accept;
                vld_p2 <= vld_p1;
                // p3: frame integration; the dump cycle restarts the accumulator from zero
                if (vld_p2) begin
                    if (&cnt) begin
                        corr_I    <= acc_i + sext(p_i_p2);
                        corr_Q    <= acc_q + sext(p_q_p2);
                        acc_i     <= '0;
                        acc_q     <= '0;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                    end else begin
                        acc_i <= acc_i + sext(p_i_p2);
                        acc_q <= acc_q + sext(p_q_p2);
                        cnt   <= cnt + ACC_LOG2'(1);
                    end
                end
            end
        end
    end
endmodule
